// File: rtl/mmio_alu_bank.sv
// rtl/mmio_alu_bank.sv - memory-mapped bank of independent multi-cycle ALU channels
//
// Each channel occupies a 64-byte window starting at BASE_ADDR + ch*64:
//   +0 IN1 (RW), +8 IN2 (RW), +16 OUT (RO), +24 CTRL (RW), +32 STATUS (RO)
//   CTRL:   bit0 START (write-1 pulse, reads 0), bits[2:1] OP, bit3 IEN
//   STATUS: bit0 DONE, bit1 BUSY, bit2 OVERRUN (DONE/OVERRUN clear on read)
//
// Ports:
//   clk    - single clock, rising edge
//   rst    - synchronous active-high reset
//   addr   - CPU byte address
//   wdata  - CPU write data
//   rden   - read strobe (wins over wren when both are high)
//   wren   - write strobe
//   hit    - combinational: addr falls inside this bank's window
//   rdata  - registered read data, valid one cycle after a hit read
//   rvalid - rdata valid
//   irq    - per-channel interrupt, registered DONE & IEN
module mmio_alu_bank #(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 14,
    parameter int N_CH      = 4,
    parameter int LATENCY   = 50000,
    parameter int BASE_ADDR = 15360
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rden,
    input  logic              wren,
    output logic              hit,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic [N_CH-1:0]   irq
);
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [31:0] WIN_LO = 32'(BASE_ADDR);
    localparam logic [31:0] WIN_HI = 32'(BASE_ADDR + N_CH * 64);

    localparam logic [5:0] OFF_IN1  = 6'd0;
    localparam logic [5:0] OFF_IN2  = 6'd8;
    localparam logic [5:0] OFF_OUT  = 6'd16;
    localparam logic [5:0] OFF_CTRL = 6'd24;
    localparam logic [5:0] OFF_STAT = 6'd32;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    logic [31:0]       w_addr_ext;
    logic [CH_W-1:0]   w_ch;
    logic [5:0]        w_off;
    logic              w_wr;
    logic [DATA_W-1:0] w_rd_val;

    logic [DATA_W-1:0] w_in1_a [N_CH];
    logic [DATA_W-1:0] w_in2_a [N_CH];
    logic [DATA_W-1:0] w_out_a [N_CH];
    logic [2:0]        w_ctrl_a [N_CH];
    logic [2:0]        w_stat_a [N_CH];

    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid;

    assign w_addr_ext = 32'(addr);
    assign hit        = (w_addr_ext >= WIN_LO) && (w_addr_ext < WIN_HI);
    assign w_ch       = CH_W'((w_addr_ext - WIN_LO) >> 6);
    assign w_off      = addr[5:0];
    // A simultaneous read and write serves the read only.
    assign w_wr       = wren && !rden && hit;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        state_t            r_state;
        state_t            w_state_nxt;
        logic [DATA_W-1:0] r_in1, r_in2, r_out, r_sh1, r_sh2, w_result;
        logic [1:0]        r_sh_op;
        logic [2:0]        r_ctrl;      // {IEN, OP[1:0]}
        logic [CNT_W-1:0]  r_cnt;
        logic              r_done, r_ovr, r_irq;
        logic              w_sel, w_start, w_exit, w_stat_rd;

        assign w_sel     = hit && (w_ch == CH_W'(i));
        assign w_start   = w_wr && w_sel && (w_off == OFF_CTRL) && wdata[0];
        assign w_exit    = (r_state == S_BUSY) && (r_cnt == CNT_W'(LATENCY - 1));
        assign w_stat_rd = rden && w_sel && (w_off == OFF_STAT);

        always_ff @(posedge clk) begin
            if (rst) r_state <= S_IDLE;
            else     r_state <= w_state_nxt;
        end

        always_comb begin
            w_state_nxt = r_state;
            case (r_state)
                S_IDLE:  if (w_start) w_state_nxt = S_BUSY;
                S_BUSY:  if (w_exit)  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end

        always_comb begin
            case (r_sh_op)
                2'd0:    w_result = r_sh1 + r_sh2;
                2'd1:    w_result = r_sh1 - r_sh2;
                2'd2:    w_result = r_sh1 & r_sh2;
                default: w_result = r_sh1 ^ r_sh2;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_in1   <= '0;
                r_in2   <= '0;
                r_out   <= '0;
                r_sh1   <= '0;
                r_sh2   <= '0;
                r_sh_op <= '0;
                r_ctrl  <= '0;
                r_cnt   <= '0;
                r_done  <= 1'b0;
                r_ovr   <= 1'b0;
                r_irq   <= 1'b0;
            end else begin
                if (w_wr && w_sel && (w_off == OFF_IN1))  r_in1  <= wdata;
                if (w_wr && w_sel && (w_off == OFF_IN2))  r_in2  <= wdata;
                if (w_wr && w_sel && (w_off == OFF_CTRL)) r_ctrl <= wdata[3:1];

                // Shadows freeze the operands so IN rewrites during BUSY are harmless.
                if (w_start && (r_state == S_IDLE)) begin
                    r_sh1   <= r_in1;
                    r_sh2   <= r_in2;
                    r_sh_op <= wdata[2:1];
                    r_cnt   <= '0;
                end else if ((r_state == S_BUSY) && !w_exit) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end

                if (w_exit) r_out <= w_result;

                // Completion outranks a same-cycle STATUS read clear.
                if (w_exit)         r_done <= 1'b1;
                else if (w_stat_rd) r_done <= 1'b0;

                // START while BUSY (including the exit cycle) is dropped but flagged.
                if (w_start && (r_state == S_BUSY)) r_ovr <= 1'b1;
                else if (w_stat_rd)                 r_ovr <= 1'b0;

                r_irq <= r_done && r_ctrl[2];
            end
        end

        assign w_in1_a[i]  = r_in1;
        assign w_in2_a[i]  = r_in2;
        assign w_out_a[i]  = r_out;
        assign w_ctrl_a[i] = r_ctrl;
        assign w_stat_a[i] = {r_ovr, (r_state == S_BUSY), r_done};
        assign irq[i]      = r_irq;
    end

    always_comb begin
        w_rd_val = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_ch == CH_W'(i)) begin
                case (w_off)
                    OFF_IN1:  w_rd_val = w_in1_a[i];
                    OFF_IN2:  w_rd_val = w_in2_a[i];
                    OFF_OUT:  w_rd_val = w_out_a[i];
                    OFF_CTRL: w_rd_val = DATA_W'({w_ctrl_a[i], 1'b0});
                    OFF_STAT: w_rd_val = DATA_W'(w_stat_a[i]);
                    default:  w_rd_val = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= rden && hit;
            r_rdata  <= (rden && hit) ? w_rd_val : '0;
        end
    end

    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;

endmodule

// File: doc/mmio_alu_bank.md
MMIO_ALU_BANK -- requirements
Module: mmio_alu_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 64: data width of all channel registers and the data bus.
REQ-002 SHALL have parameter ADDR_W, default 14: byte-address width of the CPU data-memory address bus.
REQ-003 SHALL have parameter N_CH, default 4, range 1..8: number of independent ALU channels.
REQ-004 SHALL have parameter LATENCY, default 50000, minimum 1: busy cycles per operation.
REQ-005 SHALL have parameter BASE_ADDR, default 15360: byte address of channel 0, 64-byte aligned.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-008 SHALL have port addr, input, ADDR_W bits: CPU byte address.
REQ-009 SHALL have port wdata, input, DATA_W bits: CPU write data.
REQ-010 SHALL have port rden, input, 1 bit: read strobe, one access per asserted cycle.
REQ-011 SHALL have port wren, input, 1 bit: write strobe, one access per asserted cycle.
REQ-012 SHALL have port hit, output, 1 bit: combinational address-in-window flag, used by the top level to steer data memory away.
REQ-013 SHALL have port rdata, output, DATA_W bits: registered read data.
REQ-014 SHALL have port rvalid, output, 1 bit: rdata is valid this cycle.
REQ-015 SHALL have port irq, output, N_CH bits: per-channel interrupt.

Function
REQ-016 SHALL assert hit iff BASE_ADDR <= addr < BASE_ADDR + N_CH*64; channel = (addr-BASE_ADDR)>>6, offset = addr[5:0].
REQ-017 SHALL map per-channel offsets as: 0 IN1 (RW), 8 IN2 (RW), 16 OUT (RO), 24 CTRL (RW), 32 STATUS (RO).
REQ-018 SHALL define CTRL as: bit0 START (write-1 pulse, reads 0), bits[2:1] OP, bit3 IEN.
REQ-019 SHALL define STATUS as: bit0 DONE, bit1 BUSY, bit2 OVERRUN; all other bits read 0.
REQ-020 SHALL ignore writes to RO registers, unmapped offsets, or non-hit addresses; reads of these SHALL return 0, with rvalid still asserted if hit.
REQ-021 SHALL present read data on rdata with rvalid=1 exactly one cycle after a hit read; when rden&wren are both high, the write SHALL be ignored and the read served.
REQ-022 SHALL implement a per-channel FSM: IDLE --START write--> BUSY; BUSY --counter==LATENCY-1--> IDLE.
REQ-023 SHALL, on START in IDLE, latch IN1, IN2 and OP into shadow copies and clear the counter; later IN writes SHALL NOT affect the running operation.
REQ-024 SHALL compute on the BUSY exit cycle OUT = f(shadows), with OP 0 add, 1 sub (IN1-IN2), 2 and, 3 xor, all modulo 2^DATA_W; it SHALL then set DONE and clear BUSY.
REQ-025 SHALL ignore START received while BUSY, except that it SHALL set OVERRUN.
REQ-026 SHALL clear DONE and OVERRUN when STATUS is read; the read SHALL return the pre-clear value.
REQ-027 SHALL give a DONE set priority over a STATUS-read clear in the same cycle (DONE stays 1).
REQ-028 SHALL allow a START accepted in the same cycle DONE is set (BUSY exit) only on the next cycle, since the channel is BUSY that cycle; such a START SHALL count as OVERRUN.
REQ-029 SHALL drive irq[i] = DONE[i] & IEN[i], registered.
REQ-030 SHALL keep channels fully independent and concurrently runnable.

Reset
REQ-031 SHALL, while rst is high at a clock edge, clear every IN1, IN2, OUT, CTRL, shadow, counter, DONE, BUSY, OVERRUN; set all FSMs to IDLE; and drive rdata=0, rvalid=0, irq=0.
REQ-032 SHALL abort an operation on mid-operation reset with no DONE and OUT=0.

Verification (LATENCY=4, N_CH=4, BASE_ADDR=15360)
REQ-033 SHALL be verified by this scenario: write ch0 IN1=5, IN2=7, CTRL=0x1; STATUS polled each cycle -> BUSY=1 for 4 cycles, then STATUS=0x1, OUT=12, and the next STATUS read returns 0.
REQ-034 SHALL be verified by this scenario: ch2 OP=1, IN1=3, IN2=5 -> OUT=0xFFFF_FFFF_FFFF_FFFE.
REQ-035 SHALL be verified by this scenario: a START 2 cycles into BUSY, then IN1 rewritten -> the result uses the original operands and STATUS=0x5.
REQ-036 SHALL be verified by this scenario: ch1 and ch3 started 1 cycle apart with IEN=1 -> irq=0b0010 then 0b1010 on consecutive cycles, and each clears after its STATUS read.
REQ-037 SHALL be verified by this scenario: a STATUS read on the exact DONE-set cycle -> returns 0x2 and DONE remains 1.
REQ-038 SHALL be verified by this scenario: rst pulsed during BUSY -> all registers read 0, irq=0, and no DONE ever appears.
